difetto_bsr_chain: RTL and testbench
====================================

Name: difetto_bsr_chain

Overview:
- Parametrised boundary-scan segment: WIDTH cells, each with capture/shift and update stages, plus a serial SI→SO path.
- Successor to the single-stage input/output boundary registers. Adds:
  - a separate update latch, so PO does not ripple while shifting;
  - per-cell observe-only masking;
  - an internal auto-shift sequencer that clocks a full WIDTH-bit frame from one START pulse.
- Sits between top-level pads and core logic. Segments are daisy-chained SO→SI by the DFT insertion pass.

Parameters:
- WIDTH, 8: number of cells; must be ≥1.
- OBSERVE_ONLY_MASK, {WIDTH{1'b0}}: bit i=1 makes cell i observe-only. PO[i]=PI[i] always; the cell still captures and shifts.
- TEST_POLARITY, 1'b1: TEST level that selects update-latch drive.
- AUTO_UPDATE, 1'b1: 1 = load the update latch on the final auto-shift edge.
- UPDATE_RESET, {WIDTH{1'b0}}: update-latch value after reset.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST_N  input  1  synchronous active-low reset.
- TEST  input  1  test-mode select (see TEST_POLARITY).
- CAPTURE  input  1  load the shift register from PI.
- SHIFT  input  1  manual single-bit shift.
- UPDATE  input  1  manual transfer of the shift register to the update latch.
- START  input  1  begin an auto-shift frame of WIDTH bits.
- SI  input  1  serial scan in.
- SO  output  1  serial scan out, sr[0].
- PI  input  WIDTH  functional/pad-side data in.
- PO  output  WIDTH  data out to core/pad.
- BUSY  output  1  auto-shift frame in progress.
- DONE  output  1  one-cycle pulse after the frame's final shift.

Behaviour:
- State:
  - sr[WIDTH-1:0], the shift register.
  - upd[WIDTH-1:0], the update latch.
  - cnt, width clog2(WIDTH+1).
  - FSM: IDLE, SHIFTING.
- Reset (RST_N=0 at an edge): sr=0, upd=UPDATE_RESET, cnt=0, FSM=IDLE, BUSY=0, DONE=0. Reset has priority over every other input and aborts an in-flight frame with no DONE.
- PO is combinational. PO[i] = (TEST==TEST_POLARITY && !OBSERVE_ONLY_MASK[i]) ? upd[i] : PI[i].
- SO = sr[0], combinational from the register.
- Shift operation: sr <= {SI, sr[WIDTH-1:1]}. The first bit in ends at index 0 after WIDTH shifts. For WIDTH=1, sr <= SI.
- IDLE, evaluated per edge:
  - CAPTURE=1: sr <= PI. CAPTURE beats SHIFT.
  - else SHIFT=1: shift.
  - UPDATE=1: upd <= sr pre-edge value, independent of CAPTURE/SHIFT in the same cycle.
  - START=1: cnt <= WIDTH and FSM→SHIFTING (BUSY=1 next cycle). START is evaluated alongside the above, so a same-cycle CAPTURE still loads first.
- SHIFTING:
  - Every edge: shift, cnt <= cnt-1. SI is sampled each BUSY cycle.
  - When cnt==1 at the edge: FSM→IDLE, BUSY=0, DONE=1 for exactly one cycle.
  - If AUTO_UPDATE=1, upd <= post-shift sr value on that same edge.
  - CAPTURE, SHIFT, UPDATE and START are ignored while BUSY.
- Frame timing: BUSY is high for exactly WIDTH cycles. DONE is high in the cycle after the last shift edge. DONE is 0 in all other cycles.
- Back-to-back frames: START in the DONE cycle is accepted (FSM is IDLE).
- TEST may change at any time. It only affects the PO mux, never sr/upd/FSM.

Test Plan:
- Reset, TEST=1: hold RST_N=0 two cycles → PO=UPDATE_RESET, SO=0, BUSY=0, DONE=0; with TEST=0, PO tracks PI=8'hA5.
- Capture + manual shift (WIDTH=8): PI=8'hC3, pulse CAPTURE, then 8 SHIFT cycles with SI=0 → SO emits 1,1,0,0,0,0,1,1 (LSB first); sr=0.
- Auto frame: START, SI stream 1,0,1,1,0,0,1,0 → BUSY high 8 cycles, DONE one cycle after; upd=8'h4D (AUTO_UPDATE=1); TEST=1 → PO=8'h4D.
- Observe-only: OBSERVE_ONLY_MASK=8'h0F, upd=8'hFF, PI=8'h00, TEST=1 → PO=8'hF0.
- Ignored commands while BUSY: assert CAPTURE/UPDATE/START mid-frame → sr/upd unchanged except by shifting; BUSY still exactly 8 cycles; single DONE.
- Reset mid-frame: RST_N=0 after 3 shifts → next cycle BUSY=0, DONE never asserts, sr=0, upd=UPDATE_RESET.

Source files
------------

// File: rtl/difetto_bsr_chain.sv
`default_nettype none
// ============================================================================
// Module   : difetto_bsr_chain
// Purpose  : Parametrised boundary-scan segment. WIDTH cells, each with a
//            capture/shift stage and a separate update latch, plus a serial
//            SI->SO path. An internal sequencer shifts a full WIDTH-bit frame
//            from a single START pulse.
// Ports    : CLK      - clock, all state changes on the rising edge
//            RST_N    - synchronous active-low reset
//            TEST     - test-mode select for the PO mux
//            CAPTURE  - load shift register from PI
//            SHIFT    - manual single-bit shift
//            UPDATE   - manual shift register -> update latch transfer
//            START    - begin an auto-shift frame
//            SI / SO  - serial scan in / out (SO = sr[0])
//            PI / PO  - pad-side data in / data out to core or pad
//            BUSY     - auto-shift frame in progress
//            DONE     - one-cycle pulse after the frame's final shift
// Revision : 1.0 - initial release
// ============================================================================
module difetto_bsr_chain #(
  parameter int               WIDTH             = 8,
  parameter logic [WIDTH-1:0] OBSERVE_ONLY_MASK = {WIDTH{1'b0}},
  parameter logic             TEST_POLARITY     = 1'b1,
  parameter logic             AUTO_UPDATE       = 1'b1,
  parameter logic [WIDTH-1:0] UPDATE_RESET      = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             TEST,
  input  logic             CAPTURE,
  input  logic             SHIFT,
  input  logic             UPDATE,
  input  logic             START,
  input  logic             SI,
  output logic             SO,
  input  logic [WIDTH-1:0] PI,
  output logic [WIDTH-1:0] PO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_SHIFTING = 1'b1;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] shift_next;
  logic [CNT_W-1:0] cnt;
  logic [0:0]       state;
  logic             done_q;

  // A one-cell segment has no upper bits to move down, so SI loads directly.
  generate
    if (WIDTH == 1) begin : g_shift_single
      assign shift_next = SI;
    end else begin : g_shift_multi
      assign shift_next = {SI, sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sr     <= '0;
      upd    <= UPDATE_RESET;
      cnt    <= '0;
      state  <= ST_IDLE;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (CAPTURE) begin
            sr <= PI;
          end else if (SHIFT) begin
            sr <= shift_next;
          end
          // Update takes the pre-edge shift register, regardless of any
          // capture or shift happening on the same edge.
          if (UPDATE) begin
            upd <= sr;
          end
          if (START) begin
            cnt   <= CNT_W'(WIDTH);
            state <= ST_SHIFTING;
          end
        end
        default: begin
          // Manual commands are ignored for the whole frame.
          sr  <= shift_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
            if (AUTO_UPDATE) begin
              upd <= shift_next;
            end
          end
        end
      endcase
    end
  end

  assign SO   = sr[0];
  assign BUSY = (state == ST_SHIFTING);
  assign DONE = done_q;

  // Observe-only cells always pass PI straight through.
  assign PO = (TEST == TEST_POLARITY)
            ? ((upd & ~OBSERVE_ONLY_MASK) | (PI & OBSERVE_ONLY_MASK))
            : PI;

endmodule
`default_nettype wire

// File: tb/tb_difetto_bsr_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_difetto_bsr_chain
// Purpose  : Self-checking bench for difetto_bsr_chain (WIDTH=8, cells 3:0
//            observe-only, non-zero update reset value).
// Revision : 1.0 - initial release
// ============================================================================
module tb_difetto_bsr_chain;

  localparam int         W     = 8;
  localparam logic [7:0] MASK  = 8'h0F;
  localparam logic [7:0] URST  = 8'h3C;

  logic       clk = 1'b0;
  logic       rst_n, test, capture, shift, update, start, si;
  logic       so, busy, done;
  logic [7:0] pi, po;

  int checks = 0;
  int errors = 0;

  difetto_bsr_chain #(
    .WIDTH(W), .OBSERVE_ONLY_MASK(MASK), .TEST_POLARITY(1'b1),
    .AUTO_UPDATE(1'b1), .UPDATE_RESET(URST)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .TEST(test), .CAPTURE(capture), .SHIFT(shift),
    .UPDATE(update), .START(start), .SI(si), .SO(so), .PI(pi), .PO(po),
    .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame_left counts remaining auto-shift edges.
  logic [7:0] m_sr, m_upd, m_old;
  int         frame_left = 0;
  logic       m_done;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_sr = 8'h00; m_upd = URST; frame_left = 0; m_done = 1'b0;
    end else if (frame_left > 0) begin
      m_sr = (m_sr >> 1) | (8'(si) << 7);
      frame_left = frame_left - 1;
      m_done = (frame_left == 0);
      if (m_done) m_upd = m_sr;
    end else begin
      m_done = 1'b0;
      m_old  = m_sr;
      if (capture)    m_sr = pi;
      else if (shift) m_sr = (m_sr >> 1) | (8'(si) << 7);
      if (update)     m_upd = m_old;
      if (start)      frame_left = W;
    end
  end

  function automatic logic [7:0] exp_po();
    logic [7:0] r;
    for (int i = 0; i < W; i++)
      r[i] = (test && !MASK[i]) ? m_upd[i] : pi[i];
    return r;
  endfunction

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    chk("po",   32'(po),   32'(exp_po()));
    chk("so",   32'(so),   32'(m_sr[0]));
    chk("busy", 32'(busy), 32'(frame_left > 0));
    chk("done", 32'(done), 32'(m_done));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] c3;
  logic [7:0] stream;
  int         nbusy, ndone;

  initial begin
    rst_n = 0; test = 1; capture = 0; shift = 0; update = 0; start = 0;
    si = 0; pi = 8'hA5;

    // Reset
    tick(); tick();
    chk("rst_po_test1", 32'(po), 32'h35);
    chk("rst_so",   32'(so), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    test = 0; #1;
    chk("rst_po_test0", 32'(po), 32'hA5);
    rst_n = 1;

    // Capture then manual shift, LSB first
    pi = 8'hC3; c3 = 8'hC3; capture = 1;
    tick();
    capture = 0; shift = 1; si = 0;
    for (int i = 0; i < 8; i++) begin
      chk("shift_so", 32'(so), 32'(c3[i]));
      tick();
    end
    shift = 0; update = 1;
    tick();
    update = 0; test = 1; #1;
    chk("sr_empty_po", 32'(po), 32'h03);

    // Auto frame with SI stream 1,0,1,1,0,0,1,0
    stream = 8'b0100_1101;
    start = 1;
    tick();
    start = 0;
    nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      si = stream[i];
      nbusy += int'(busy);
      tick();
    end
    si = 0; pi = 8'h0A; #1;
    chk("frame_busy_cycles", 32'(nbusy), 8);
    chk("frame_done", 32'(done), 1);
    chk("frame_busy_end", 32'(busy), 0);
    chk("frame_po", 32'(po), 32'h4A);
    tick();
    chk("frame_done_pulse", 32'(done), 0);

    // Observe-only: upd=FF, PI=00 -> PO=F0
    pi = 8'hFF; capture = 1;
    tick();
    capture = 0; update = 1;
    tick();
    update = 0; pi = 8'h00; test = 1; #1;
    chk("observe_only_po", 32'(po), 32'hF0);

    // Commands ignored while busy
    start = 1;
    tick();
    start = 0; nbusy = 0; ndone = 0;
    for (int i = 0; i < 12; i++) begin
      si = 1'($urandom);
      capture = (i == 2); update = (i == 3); start = (i == 4); shift = (i == 5);
      pi = 8'($urandom);
      nbusy += int'(busy); ndone += int'(done);
      tick();
    end
    capture = 0; update = 0; start = 0; shift = 0;
    chk("busy_ignore_cycles", 32'(nbusy), 8);
    chk("busy_ignore_done", 32'(ndone), 1);

    // Reset mid-frame
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin si = 1; tick(); end
    rst_n = 0;
    tick();
    pi = 8'h00; test = 1; #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_so",   32'(so), 0);
    chk("midrst_po",   32'(po), 32'h30);
    rst_n = 1; ndone = 0;
    for (int i = 0; i < 10; i++) begin ndone += int'(done); tick(); end
    chk("midrst_no_done", 32'(ndone), 0);

    // Randomised traffic, including back-to-back frames and odd resets
    for (int i = 0; i < 1500; i++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      test    = 1'($urandom);
      capture = ($urandom_range(0, 3) == 0);
      shift   = 1'($urandom);
      update  = ($urandom_range(0, 3) == 0);
      start   = (done || $urandom_range(0, 9) == 0);
      si      = 1'($urandom);
      pi      = 8'($urandom);
      tick();
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
